// File: rtl/stack_mem_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// stack_mem_ctrl
// Front end for M_circuit. In IDLE the CPU drives M_circuit through this
// block unchanged (AR/DR/MEMLOAD pass-through). Hardware PUSH/POP requests
// borrow the memory port for a short sequence and operate on a downward
// growing stack in [STACK_BASE, STACK_TOP].
//
// Optional feature macro: STACK_PEEK_EN
//   When defined, adds the 'peek' request: it reads the top of stack like a
//   pop but leaves sp alone. It has the lowest priority (push > pop > peek).
//
// Ports
//   clk_50       in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   push         in   push request, sampled while ready=1
//   pop          in   pop request, sampled while ready=1
//   push_data    in   word to push, captured together with push
//   clear_flags  in   synchronous clear of overflow/underflow
//   peek         in   (STACK_PEEK_EN only) read top of stack without popping
//   cpu_ar       in   CPU address, forwarded while IDLE
//   cpu_dr       in   CPU write data, forwarded while IDLE
//   cpu_memload  in   CPU MEMLOAD, forwarded while IDLE
//   mem_data_out in   data_out of M_circuit
//   AR           out  address to M_circuit
//   DR           out  write data to M_circuit
//   CU           out  MEMLOAD strobe to M_circuit
//   ready        out  1 while IDLE; new requests are accepted
//   done         out  one-cycle completion pulse
//   err          out  qualifies done: operation was rejected
//   pop_data     out  last popped/peeked word, held until the next one
//   sp           out  stack pointer, next free slot
//   count        out  number of stored words
//   full, empty  out  stack status, combinational from sp
//   overflow     out  sticky: push attempted while full
//   underflow    out  sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module stack_mem_ctrl #(
    parameter int unsigned           ADDR_W     = 12,
    parameter int unsigned           DATA_W     = 32,
    parameter int unsigned           MEM_W      = 38,
    parameter logic [ADDR_W-1:0]     STACK_BASE = 12'h44C,
    parameter logic [ADDR_W-1:0]     STACK_TOP  = 12'hFFF
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 clear_flags,
`ifdef STACK_PEEK_EN
    input  logic                 peek,
`endif
    input  logic [ADDR_W-1:0]    cpu_ar,
    input  logic [DATA_W-1:0]    cpu_dr,
    input  logic                 cpu_memload,
    input  logic [MEM_W-1:0]     mem_data_out,
    output logic [ADDR_W-1:0]    AR,
    output logic [DATA_W-1:0]    DR,
    output logic                 CU,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [DATA_W-1:0]    pop_data,
    output logic [ADDR_W-1:0]    sp,
    output logic [ADDR_W-1:0]    count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);

    // Number of slots between STACK_BASE and STACK_TOP inclusive.
    localparam logic [ADDR_W-1:0] L_DEPTH =
        ADDR_W'(32'(STACK_TOP) - 32'(STACK_BASE) + 32'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUSH_WR = 2'd1,
        S_POP_RD  = 2'd2,
        S_POP_CAP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_sp;
    logic [DATA_W-1:0]   r_push_data;
    logic [DATA_W-1:0]   r_pop_data;
    logic                r_overflow;
    logic                r_underflow;

    logic [ADDR_W-1:0]   w_count;
    logic [ADDR_W-1:0]   w_sp_inc;
    logic                w_full;
    logic                w_empty;
    logic                w_is_peek;
    logic                w_peek_req;
    logic                w_accept_push;
    logic                w_set_ovf;
    logic                w_set_unf;
    logic                w_sp_dec_en;
    logic                w_sp_inc_en;
    logic                w_cap_en;

    // Only the low DATA_W bits of the memory word carry stack data.
    logic                w_unused_mem_hi;
    assign w_unused_mem_hi = ^mem_data_out[MEM_W-1:DATA_W];

    // Stack status derived from sp.
    assign w_count  = ADDR_W'(STACK_TOP - r_sp);
    assign w_full   = (w_count == L_DEPTH);
    assign w_empty  = (w_count == '0);
    assign w_sp_inc = ADDR_W'(r_sp + ADDR_W'(1));

`ifdef STACK_PEEK_EN
    // Remembers whether the read sequence in flight is a peek.
    logic r_is_peek;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_is_peek <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_is_peek <= !push && !pop && peek;
        end
    end

    assign w_is_peek  = r_is_peek;
    assign w_peek_req = peek;
`else
    assign w_is_peek  = 1'b0;
    assign w_peek_req = 1'b0;
`endif

    assign w_accept_push = (r_state == S_IDLE) && push;

    // Datapath enables; rejected operations leave sp and pop_data alone.
    assign w_sp_dec_en = (r_state == S_PUSH_WR) && !w_full;
    assign w_sp_inc_en = (r_state == S_POP_CAP) && !w_empty && !w_is_peek;
    assign w_cap_en    = (r_state == S_POP_CAP) && !w_empty;
    assign w_set_ovf   = (r_state == S_PUSH_WR) && w_full;
    assign w_set_unf   = (r_state == S_POP_CAP) && w_empty && !w_is_peek;

    // State register.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory-port muxing. Reset forces CU low immediately
    // so an aborted push never produces a partial write.
    always_comb begin
        w_state_nxt = r_state;
        AR          = cpu_ar;
        DR          = cpu_dr;
        CU          = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                AR = cpu_ar;
                DR = cpu_dr;
                CU = cpu_memload && !rst;
                if (push) begin
                    w_state_nxt = S_PUSH_WR;
                end else if (pop || w_peek_req) begin
                    w_state_nxt = S_POP_RD;
                end
            end
            S_PUSH_WR: begin
                AR          = r_sp;
                DR          = r_push_data;
                CU          = !w_full && !rst;
                done        = 1'b1;
                err         = w_full;
                w_state_nxt = S_IDLE;
            end
            S_POP_RD: begin
                AR          = w_sp_inc;
                DR          = r_push_data;
                w_state_nxt = S_POP_CAP;
            end
            S_POP_CAP: begin
                AR          = w_sp_inc;
                DR          = r_push_data;
                done        = 1'b1;
                err         = w_empty;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Push data is latched at accept so the requester may change it.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_push_data <= '0;
        end else if (w_accept_push) begin
            r_push_data <= push_data;
        end
    end

    // Stack pointer: one slot down per push, one slot up per pop.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_sp <= STACK_TOP;
        end else if (w_sp_dec_en) begin
            r_sp <= ADDR_W'(r_sp - ADDR_W'(1));
        end else if (w_sp_inc_en) begin
            r_sp <= w_sp_inc;
        end
    end

    // Captured pop/peek word.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_pop_data <= '0;
        end else if (w_cap_en) begin
            r_pop_data <= mem_data_out[DATA_W-1:0];
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_set_unf) begin
                r_underflow <= 1'b1;
            end else if (clear_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign pop_data  = r_pop_data;
    assign sp        = r_sp;
    assign count     = w_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
